// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared forward-select type, ALUOp encodings and width defaults.
// FORWARD_EN selects MEM/WB forwarding; when undefined the stage interlocks on every RAW.
package id_ex_stage_pkg;

  localparam int DATA_W_DEFAULT  = 32;
  localparam int REG_AW_DEFAULT  = 5;
  localparam int ALUOP_W_DEFAULT = 5;

`ifdef FORWARD_EN
  localparam bit FORWARD_ON = 1'b1;
`else
  localparam bit FORWARD_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // ALU opcodes shared with the ALU's ctrl_encode_def.
  localparam logic [4:0] ALUOp_NOP  = 5'b00000;
  localparam logic [4:0] ALUOp_LUI  = 5'b00001;
  localparam logic [4:0] ALUOp_ADD  = 5'b00011;
  localparam logic [4:0] ALUOp_SUB  = 5'b00100;
  localparam logic [4:0] ALUOp_AND  = 5'b00101;
  localparam logic [4:0] ALUOp_OR   = 5'b00110;
  localparam logic [4:0] ALUOp_XOR  = 5'b00111;
  localparam logic [4:0] ALUOp_NOR  = 5'b01000;
  localparam logic [4:0] ALUOp_SLT  = 5'b01001;
  localparam logic [4:0] ALUOp_SLTU = 5'b01010;
  localparam logic [4:0] ALUOp_SLL  = 5'b01011;
  localparam logic [4:0] ALUOp_SRL  = 5'b01100;
  localparam logic [4:0] ALUOp_SRA  = 5'b01101;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: per-operand bypass select, MEM over WB over register value.
// Bypassing is compiled out (register value only) unless FORWARD_EN is defined.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] reg_val_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output logic [DATA_W-1:0] val_o,
  output fwd_sel_e          sel_o
);

  logic mem_hit, wb_hit;

  // $0 is hard-wired zero, so a write targeting it must never be bypassed.
  assign mem_hit = FORWARD_ON && mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == src_i);
  assign wb_hit  = FORWARD_ON && wb_reg_write_i  && (wb_rd_i  != '0) && (wb_rd_i  == src_i);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    sel_o = FWD_REG;
    val_o = reg_val_i;
    if (mem_hit) begin
      sel_o = FWD_MEM;
      val_o = mem_result_i;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
      val_o = wb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register, EX operand bypass and load-use / RAW stall control.
// Define FORWARD_EN for MEM/WB forwarding with load-use stalls only; otherwise full interlock.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int REG_AW  = REG_AW_DEFAULT,
  parameter int ALUOP_W = ALUOP_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [DATA_W-1:0]  id_rs_val,
  input  logic [DATA_W-1:0]  id_rt_val,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_use_imm,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [4:0]         id_shamt,
  input  logic               id_shift_var,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               flush,
  input  logic               mem_reg_write,
  input  logic [REG_AW-1:0]  mem_rd,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic               wb_reg_write,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [DATA_W-1:0]  wb_result,
  output logic               stall_id,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_a,
  output logic [DATA_W-1:0]  ex_b,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [4:0]         ex_shamt,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg
);

  typedef struct packed {
    logic               valid;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  rt_val;
    logic [DATA_W-1:0]  imm;
    logic               use_imm;
    logic [ALUOP_W-1:0] aluop;
    logic [4:0]         shamt;
    logic               shift_var;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
  } ex_regs_t;

  function automatic ex_regs_t bubble();
    ex_regs_t b;
    b       = '0;
    b.aluop = ALUOP_W'(ALUOp_NOP);
    return b;
  endfunction

  ex_regs_t    ex_q, ex_d, id_fields;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  fwd_sel_e    rs_sel, rt_sel;
  logic        load_use, rs_busy, rt_busy, hazard;

  assign id_fields = '{
    valid:      id_valid,     rs:        id_rs,        rt:        id_rt,
    rd:         id_rd,        rs_val:    id_rs_val,    rt_val:    id_rt_val,
    imm:        id_imm,       use_imm:   id_use_imm,   aluop:     id_aluop,
    shamt:      id_shamt,     shift_var: id_shift_var, reg_write: id_reg_write,
    mem_read:   id_mem_read,  mem_write: id_mem_write, mem_to_reg: id_mem_to_reg
  };

  // A load's data exists only after MEM, so a consumer right behind it must wait one cycle.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                    ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));

  // Without bypassing, any source still owned by EX or MEM is stale in the register file.
  assign rs_busy = (id_rs != '0) &&
                   ((ex_q.valid && ex_q.reg_write && (ex_q.rd == id_rs)) ||
                    (mem_reg_write && (mem_rd == id_rs)));
  assign rt_busy = (id_rt != '0) &&
                   ((ex_q.valid && ex_q.reg_write && (ex_q.rd == id_rt)) ||
                    (mem_reg_write && (mem_rd == id_rt)));

  assign hazard   = FORWARD_ON ? load_use : (id_valid && (rs_busy || rt_busy));
  assign stall_id = !rst && !flush && hazard;

  always_comb begin
    ex_d = id_fields;
    if (flush || hazard) ex_d = bubble();
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all sequential state avoids simulation races.
    if (rst) ex_q <= bubble();
    else     ex_q <= ex_d;
  end

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_i          (ex_q.rs),
    .reg_val_i      (ex_q.rs_val),
    .mem_reg_write_i(mem_reg_write),
    .mem_rd_i       (mem_rd),
    .mem_result_i   (mem_result),
    .wb_reg_write_i (wb_reg_write),
    .wb_rd_i        (wb_rd),
    .wb_result_i    (wb_result),
    .val_o          (fwd_rs),
    .sel_o          (rs_sel)
  );

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_i          (ex_q.rt),
    .reg_val_i      (ex_q.rt_val),
    .mem_reg_write_i(mem_reg_write),
    .mem_rd_i       (mem_rd),
    .mem_result_i   (mem_result),
    .wb_reg_write_i (wb_reg_write),
    .wb_rd_i        (wb_rd),
    .wb_result_i    (wb_result),
    .val_o          (fwd_rt),
    .sel_o          (rt_sel)
  );

  always_comb begin
    if (!FORWARD_ON) assert (rs_sel == FWD_REG && rt_sel == FWD_REG);
  end

  assign ex_valid      = ex_q.valid;
  assign ex_a          = fwd_rs;
  assign ex_b          = ex_q.use_imm ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_aluop      = ex_q.aluop;
  assign ex_shamt      = ex_q.shift_var ? fwd_rs[4:0] : ex_q.shamt;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand supply for the 5-stage MIPS pipeline. The block latches decoded operands and control from ID, then resolves RAW hazards by forwarding from MEM and WB. It drives the ALU's A, B, ALUOp and Shamt inputs combinationally from the registered state. It also detects load-use hazards, stalls ID and inserts bubbles into EX.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register-index width
- ALUOP_W, 5, ALU opcode width (ctrl_encode_def encodings)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source register indices
- id_rd  in  REG_AW  destination index (already muxed rd/rt/31)
- id_rs_val, id_rt_val  in  DATA_W  register-file read data
- id_imm  in  DATA_W  extended immediate
- id_use_imm  in  1  B operand = immediate
- id_aluop  in  ALUOP_W  ALU opcode
- id_shamt  in  5  instruction shamt field
- id_shift_var  in  1  SLLV/SRLV/SRAV: Shamt = A[4:0]
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control
- flush  in  1  branch/jump redirect; kill instruction entering EX
- mem_reg_write  in  1, mem_rd  in  REG_AW, mem_result  in  DATA_W  EX/MEM forward source
- wb_reg_write  in  1, wb_rd  in  REG_AW, wb_result  in  DATA_W  MEM/WB forward source
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_a, ex_b  out  DATA_W  ALU A and B
- ex_aluop  out  ALUOP_W;  ex_shamt  out  5
- ex_store_data  out  DATA_W  forwarded rt value for SW
- ex_rd  out  REG_AW;  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1

## Operation
- Registered fields: valid, rs, rt, rd, rs_val, rt_val, imm, use_imm, aluop, shamt, shift_var, and the four control bits.
- Forwarding per operand (rs, rt): if mem_reg_write, mem_rd≠0 and mem_rd==src, select mem_result. Otherwise, if the same test holds for WB, select wb_result. Otherwise select the registered value. MEM has priority over WB. Register 0 is never forwarded.
- ex_a = fwd(rs). ex_b = use_imm ? imm : fwd(rt). ex_store_data = fwd(rt) always.
- ex_shamt = shift_var ? fwd(rs)[4:0] : shamt.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt). The hazard asserts stall_id and loads a bubble into EX.
- Bubble means valid=0, reg_write/mem_read/mem_write/mem_to_reg=0, aluop=ALUOp_NOP, and all data fields 0.
- flush loads a bubble and forces stall_id=0. Flush wins over a simultaneous load-use stall.
- The register file is write-first, so WB-to-ID needs no bypass here.

## Timing
- Reset: all registered fields 0, aluop=ALUOp_NOP. Every output therefore reads 0 or NOP after reset. stall_id=0 during and after reset.
- Reset wins over flush and stall and may hit at any cycle. It discards the in-flight EX instruction.
- Latency: ID inputs appear in the EX registers 1 cycle later. ex_a, ex_b, ex_shamt and ex_store_data are combinational from the registers and the forward buses, with no added latency.
- stall_id is combinational in the same cycle. A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, and the dependent instruction reads it via WB forwarding one cycle later.
- Back-to-back loads with chained dependencies stall once per dependency.

## Configuration
- FORWARD_EN defined: forwarding as above; only load-use stalls.
- FORWARD_EN undefined:
  - forward muxes fixed to the registered value;
  - stall_id asserts whenever an ID source (≠0) matches ex_rd (ex_reg_write & ex_valid) or mem_rd (mem_reg_write);
  - each stall cycle inserts a bubble;
  - flush still overrides.

## Structure
- Shared package:
  - forward-select enum FWD_REG/FWD_MEM/FWD_WB;
  - ALUOp encodings (ALUOp_NOP etc.) from ctrl_encode_def;
  - DATA_W/REG_AW defaults.
- Sub-module fwd_mux: one instance each for rs and rt. It takes src index, registered value and both forward buses, and returns value plus select.

## Test plan
- ADD $3,$1,$2 then SUB $4,$3,$1, with $1=5, $2=7. The SUB cycle must show ex_a=12 via MEM forwarding and ex_b=5.
- Same $3 written by the instructions in both MEM (=9) and WB (=4), with an ID read of $3. ex_a must be 9 (MEM priority).
- LW $5 then ADD $6,$5,$5. stall_id=1 for 1 cycle and EX holds a bubble (ex_valid=0, ex_reg_write=0). Then ex_a=ex_b=loaded value via WB.
- Write to $0 in MEM with mem_result=0xDEAD while ID reads $0. ex_a must be 0.
- Load-use hazard coincident with flush=1. stall_id must be 0 and EX must hold a bubble. Reset asserted mid-stream must give all outputs 0/NOP on the next edge.
- SRAV with rs forwarded as 0x23. ex_shamt must be 3. Without FORWARD_EN, the same sequence must stall 2 cycles.
